bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Produces the four BCD digits consumed by the seven-segment display driver: BCD3 (thousands) to BCD0 (units).
- Sits between measurement/PWM logic and the display. Converts an unsigned binary value on a Start/Done handshake.
- Holds the last result stable so the display multiplexer can sample it at any time.

---
 rtl/bin_to_bcd_seq.sv | 99 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 127 ++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). Converts one value per
// Start/Done handshake and holds the saturated 4-digit result for the display.
module bin_to_bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [BIN_W-1:0] Binary,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow,
  output logic [3:0]       BCD3,
  output logic [3:0]       BCD2,
  output logic [3:0]       BCD1,
  output logic [3:0]       BCD0
);

  localparam int SCR_W = 16 + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [SCR_W-1:0]   scratch, scratch_adj, scratch_shl;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pending;
  logic               in_ovf;
  logic               last_shift;
  logic [BIN_W-1:0]   sat;

  assign in_ovf     = 32'(Binary) > 32'(MAX_VAL);
  assign sat        = in_ovf ? BIN_W'(MAX_VAL) : Binary;
  assign last_shift = (cnt == CNT_W'(BIN_W - 1));

  // Add-3 is applied per digit independently; a digit >= 5 would exceed 9 after doubling.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[BIN_W + 4*i +: 4] >= 4'd5)
        scratch_adj[BIN_W + 4*i +: 4] = scratch[BIN_W + 4*i +: 4] + 4'd3;
    end
    scratch_shl = {scratch_adj[SCR_W-2:0], 1'b0};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      scratch     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      Overflow    <= 1'b0;
      BCD3        <= 4'd0;
      BCD2        <= 4'd0;
      BCD1        <= 4'd0;
      BCD0        <= 4'd0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          scratch     <= {16'b0, sat};
          ovf_pending <= in_ovf;
          cnt         <= '0;
        end
        SHIFT: begin
          scratch <= scratch_shl;
          cnt     <= cnt + CNT_W'(1);
          // Outputs are taken from the post-shift value so they never expose partial digits.
          if (last_shift) begin
            BCD3     <= scratch_shl[SCR_W-1  -: 4];
            BCD2     <= scratch_shl[SCR_W-5  -: 4];
            BCD1     <= scratch_shl[SCR_W-9  -: 4];
            BCD0     <= scratch_shl[SCR_W-13 -: 4];
            Overflow <= ovf_pending;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: hand-computed BCD results, latency,
// Busy length, saturation, back-to-back throughput and mid-conversion reset.
module tb_bin_to_bcd_seq;
  localparam int BIN_W = 14;

  logic             Clk = 1'b0;
  logic             Reset, Start;
  logic [BIN_W-1:0] Binary;
  logic             Busy, Done, Overflow;
  logic [3:0]       BCD3, BCD2, BCD1, BCD0;
  logic [16:0]      res;
  logic [16:0]      prev;
  int               n_chk = 0;
  int               n_err = 0;

  always #5 Clk = ~Clk;

  bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Binary(Binary),
    .Busy(Busy), .Done(Done), .Overflow(Overflow),
    .BCD3(BCD3), .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0)
  );

  assign res = {Overflow, BCD3, BCD2, BCD1, BCD0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One conversion with a single-cycle Start pulse; Done expected on the 15th cycle.
  task automatic convert(input string tag, input int val, input logic [16:0] exp);
    int cyc = 0, busy = 0;
    bit stable = 1'b1, seen = 1'b0;
    @(negedge Clk); Binary = BIN_W'(val); Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk); Start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge Clk);
      cyc = i;
      if (Busy) busy++;
      if (Done) begin seen = 1'b1; break; end
      if (res !== prev) stable = 1'b0;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'd15);
    chk({tag, "_result"}, 32'(res), 32'(exp));
    chk({tag, "_stable"}, 32'(stable), 32'd1);
    @(negedge Clk);
    chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
    chk({tag, "_idle"}, 32'(Busy), 32'd0);
    chk({tag, "_busy_len"}, 32'(busy), 32'd15);
    chk({tag, "_hold"}, 32'(res), 32'(exp));
    prev = exp;
  endtask

  initial begin
    int j;
    bit seen;
    Reset = 1'b0; Start = 1'b1; Binary = BIN_W'(123);
    @(negedge Clk); @(negedge Clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_out", 32'(res), 32'd0);
    Start = 1'b0; Reset = 1'b1;
    @(negedge Clk);
    chk("rst_no_start", 32'(Busy), 32'd0);
    prev = '0;

    convert("zero",  0,     {1'b0, 16'h0000});
    convert("v1234", 1234,  {1'b0, 16'h1234});
    convert("v9999", 9999,  {1'b0, 16'h9999});
    convert("v7",    7,     {1'b0, 16'h0007});
    convert("v10000",10000, {1'b1, 16'h9999});
    convert("vmax",  16383, {1'b1, 16'h9999});
    convert("v42",   42,    {1'b0, 16'h0042});

    // Back-to-back with Start held; Binary changes right after acceptance.
    @(negedge Clk); Binary = BIN_W'(5678); Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk); Binary = BIN_W'(1111);
    seen = 1'b0;
    for (int i = 2; i <= 40; i++) begin
      if (Done) begin seen = 1'b1; break; end
      @(negedge Clk);
    end
    chk("b2b_first_done", 32'(seen), 32'd1);
    chk("b2b_first", 32'(res), 32'({1'b0, 16'h5678}));
    j = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (Done) begin j = i; break; end
    end
    Start = 1'b0;
    chk("b2b_period", 32'(j), 32'd16);
    chk("b2b_second", 32'(res), 32'({1'b0, 16'h1111}));
    @(negedge Clk);
    chk("b2b_idle", 32'(Busy), 32'd0);

    // Reset during the 7th SHIFT cycle aborts the conversion.
    @(negedge Clk); Binary = BIN_W'(4321); Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk); Start = 1'b0;
    repeat (6) @(negedge Clk);
    chk("abort_busy_before", 32'(Busy), 32'd1);
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_out", 32'(res), 32'd0);
    Reset = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge Clk);
      if (Done || Busy) seen = 1'b1;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    prev = '0;
    convert("v4321", 4321, {1'b0, 16'h4321});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
